// File: rtl/ascon_soc_bridge_if.sv
// ascon_soc_bridge_if: SoC-side load, control and result-stream signals of the Ascon bridge.
interface ascon_soc_bridge_if #(parameter int W = 8);
  logic in_we;
  logic [4*W-1:0] in_data;
  logic mode, start, busy, err;
  logic out_valid, out_last, out_ready;
  logic [W-1:0] out_data;
  modport master(output in_we, in_data, mode, start, out_ready,
                 input busy, err, out_valid, out_data, out_last);
  modport slave(input in_we, in_data, mode, start, out_ready,
                output busy, err, out_valid, out_data, out_last);
endinterface

// File: rtl/ascon_soc_bridge.sv
// ascon_soc_bridge: lane loader, launcher and result streamer for an Ascon AEAD core.
// Define ASCON_BRIDGE_TAGCHK_EN to add decrypt tag checking (tag_in / auth_fail ports).
module ascon_soc_bridge #(
  parameter int K = 128,
  parameter int L = 64,
  parameter int Y = 64,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ascon_soc_bridge_if.slave soc,
  output logic [K-1:0] core_key,
  output logic [127:0] core_nonce,
  output logic [L-1:0] core_ad,
  output logic [Y-1:0] core_din,
  output logic         core_mode,
  output logic         core_start,
  input  logic         core_done,
  input  logic [Y-1:0] core_dout,
  input  logic [127:0] core_tag
`ifdef ASCON_BRIDGE_TAGCHK_EN
  ,
  input  logic [127:0] tag_in,
  output logic         auth_fail
`endif
);
  localparam int M1 = K > 128 ? K : 128;
  localparam int M2 = L > Y ? L : Y;
  localparam int NWORDS = (M1 > M2 ? M1 : M2) / W;
  localparam int NOUT = (Y + 128) / W;
  localparam int IW = $clog2(NWORDS + 1);
  localparam int DW = $clog2(NOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DRAIN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] cnt;
  logic [DW-1:0] dcnt, dlast;
  logic [Y+127:0] obuf;
  logic full, take, go, xfer;
  assign full = cnt == IW'(NWORDS);
  assign take = state == IDLE && soc.in_we && !full;
  assign go = state == IDLE && soc.start && full;
  assign xfer = soc.out_valid && soc.out_ready;
`ifdef ASCON_BRIDGE_TAGCHK_EN
  logic [127:0] tag_lat;
  logic tag_bad;
  assign tag_bad = core_mode && core_tag != tag_lat;
  // checked decrypts stream only the plaintext words, never the tag
  assign dlast = core_mode ? DW'(Y / W - 1) : DW'(NOUT - 1);
`else
  assign dlast = DW'(NOUT - 1);
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE   ? (go ? LAUNCH : IDLE) :
               state == LAUNCH ? WAIT :
               state == WAIT   ? (core_done ? DRAIN : WAIT) :
                                 (xfer && soc.out_last ? IDLE : DRAIN);
  end
  always_comb begin
    soc.busy = state != IDLE;
    core_start = state == LAUNCH;
    soc.out_valid = state == DRAIN;
    soc.out_last = state == DRAIN && dcnt == dlast;
    soc.out_data = obuf[Y+127 -: W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dcnt <= '0;
      obuf <= '0;
      core_key <= '0;
      core_nonce <= '0;
      core_ad <= '0;
      core_din <= '0;
      core_mode <= 1'b0;
      soc.err <= 1'b0;
`ifdef ASCON_BRIDGE_TAGCHK_EN
      tag_lat <= '0;
      auth_fail <= 1'b0;
`endif
    end else begin
      // fields shift in MSB first and stop once their own length is filled
      if (take) begin
        cnt <= cnt + 1'b1;
        if (cnt < IW'(K / W)) core_key <= (core_key << W) | K'(soc.in_data[W-1:0]);
        if (cnt < IW'(128 / W)) core_nonce <= (core_nonce << W) | 128'(soc.in_data[2*W-1:W]);
        if (cnt < IW'(L / W)) core_ad <= (core_ad << W) | L'(soc.in_data[3*W-1:2*W]);
        if (cnt < IW'(Y / W)) core_din <= (core_din << W) | Y'(soc.in_data[4*W-1:3*W]);
      end
      if ((soc.in_we && !take) || (soc.start && !go)) soc.err <= 1'b1;
      if (go) begin
        core_mode <= soc.mode;
`ifdef ASCON_BRIDGE_TAGCHK_EN
        tag_lat <= tag_in;
        auth_fail <= 1'b0;
`endif
      end
      if (state == WAIT && core_done) begin
`ifdef ASCON_BRIDGE_TAGCHK_EN
        obuf <= {tag_bad ? {Y{1'b0}} : core_dout, core_tag};
        auth_fail <= tag_bad;
`else
        obuf <= {core_dout, core_tag};
`endif
      end
      if (xfer) begin
        obuf <= obuf << W;
        dcnt <= soc.out_last ? '0 : dcnt + 1'b1;
        if (soc.out_last) cnt <= '0;
      end
    end
  end
endmodule
